// File: rtl/cbfp_pkg.sv
// cbfp_pkg
// Shared constants and types for the CBFP block normalizer: sample widths,
// block geometry, exponent index width and the emit FSM state encoding.
package cbfp_pkg;

    localparam int ARRAY_SIZE = 16;
    localparam int DIN_SIZE   = 23;
    localparam int DOUT_SIZE  = 11;
    localparam int BLK_BEATS  = 4;
    localparam int IDX_SIZE   = $clog2(DIN_SIZE);
    localparam int CNT_SIZE   = $clog2(BLK_BEATS);

    typedef logic signed [DIN_SIZE-1:0]  din_t;
    typedef logic signed [DOUT_SIZE-1:0] dout_t;
    typedef logic [IDX_SIZE-1:0]         idx_t;
    typedef logic [CNT_SIZE-1:0]         cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } emit_state_t;

    // Largest possible redundant-sign-bit count (all bits equal the sign)
    localparam idx_t IDX_MAX = idx_t'(DIN_SIZE - 1);

endpackage

// File: rtl/cbfp_blk_normalize_lsb_count.sv
// cbfp_lsb_count
// Combinational redundant-sign-bit counter for one input sample.
// Ports:
//   sample_i : DIN_SIZE-bit signed sample
//   count_o  : number of leading bits equal to the sign bit, sign excluded
//              (0 .. DIN_SIZE-1)
module cbfp_lsb_count
    import cbfp_pkg::*;
(
    input  logic [DIN_SIZE-1:0] sample_i,
    output logic [IDX_SIZE-1:0] count_o
);

    // Walk down from just below the sign bit; stop at the first bit that differs.
    always_comb begin
        logic run;
        count_o = '0;
        run     = 1'b1;
        for (int b = DIN_SIZE - 2; b >= 0; b--) begin
            if (run && (sample_i[b] == sample_i[DIN_SIZE-1])) begin
                count_o = count_o + idx_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cbfp_blk_normalize.sv
// cbfp_blk_normalize
// Producer side of the CBFP delay path. Collects blocks of BLK_BEATS beats of
// ARRAY_SIZE wide samples into ping-pong banks, finds the block exponent (the
// minimum redundant-sign-bit count over the block) and re-emits the block
// shifted left by that exponent and truncated to DOUT_SIZE bits.
// Ports:
//   clk          : rising-edge clock
//   rstn         : asynchronous active-low reset
//   valid_in     : din carries a valid beat
//   din          : input beat, ARRAY_SIZE signed DIN_SIZE-bit samples
//   valid_out    : dout / index_out valid
//   dout         : normalized beat, ARRAY_SIZE signed DOUT_SIZE-bit samples
//   index_out    : block exponent, constant over a block
//   blk_last_out : final beat of an output block
module cbfp_blk_normalize
    import cbfp_pkg::*;
(
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_in,
    input  logic signed [DIN_SIZE-1:0]  din [0:ARRAY_SIZE-1],
    output logic                        valid_out,
    output logic signed [DOUT_SIZE-1:0] dout [0:ARRAY_SIZE-1],
    output logic [IDX_SIZE-1:0]         index_out,
    output logic                        blk_last_out
);

    din_t        bank_q [0:1][0:BLK_BEATS-1][0:ARRAY_SIZE-1];
    idx_t        bank_idx_q [0:1];
    logic [1:0]  bank_full_q, bank_full_d;
    logic        wbank_q;
    cnt_t        wcnt_q;
    idx_t        run_min_q;

    emit_state_t state_q, state_d;
    logic        rbank_q, rbank_d;
    cnt_t        rcnt_q, rcnt_d;

    logic        valid_out_q;
    logic        blk_last_q;
    idx_t        index_q;
    dout_t       dout_q [0:ARRAY_SIZE-1];
    dout_t       dout_sel [0:ARRAY_SIZE-1];

    idx_t        lsb_cnt [0:ARRAY_SIZE-1];
    idx_t        beat_min;
    idx_t        blk_min;
    logic        close;
    logic [1:0]  close_vec;
    logic [1:0]  full_eff;
    logic        emit_last;

    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lsb
        cbfp_lsb_count u_lsb_count (
            .sample_i (din[g]),
            .count_o  (lsb_cnt[g])
        );
    end

    // Block minimum including the current beat; the first beat of a block
    // ignores the stale running minimum, so no reset-to-max is needed.
    always_comb begin
        beat_min = IDX_MAX;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (lsb_cnt[i] < beat_min) beat_min = lsb_cnt[i];
        end
        blk_min = beat_min;
        if ((wcnt_q != '0) && (run_min_q < beat_min)) blk_min = run_min_q;
        close            = valid_in && (wcnt_q == cnt_t'(BLK_BEATS - 1));
        close_vec        = 2'b00;
        close_vec[wbank_q] = close;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wbank_q       <= 1'b0;
            wcnt_q        <= '0;
            run_min_q     <= '0;
            bank_idx_q[0] <= '0;
            bank_idx_q[1] <= '0;
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < BLK_BEATS; k++)
                    for (int i = 0; i < ARRAY_SIZE; i++)
                        bank_q[b][k][i] <= '0;
        end else if (valid_in) begin
            for (int i = 0; i < ARRAY_SIZE; i++) bank_q[wbank_q][wcnt_q][i] <= din[i];
            wcnt_q    <= wcnt_q + cnt_t'(1);
            run_min_q <= blk_min;
            if (close) begin
                bank_idx_q[wbank_q] <= blk_min;
                wbank_q             <= ~wbank_q;
            end
        end
    end

    // A bank closing this cycle counts as full immediately, so emission starts
    // the next cycle and a close on the last emitted beat chains with no gap.
    always_comb begin
        state_d     = state_q;
        rbank_d     = rbank_q;
        rcnt_d      = rcnt_q;
        full_eff    = bank_full_q | close_vec;
        bank_full_d = full_eff;
        emit_last   = (state_q == EMIT) && (rcnt_q == cnt_t'(BLK_BEATS - 1));
        case (state_q)
            IDLE: begin
                if (|full_eff) begin
                    state_d = EMIT;
                    rbank_d = ~full_eff[0];
                    rcnt_d  = '0;
                end
            end
            EMIT: begin
                rcnt_d = rcnt_q + cnt_t'(1);
                if (emit_last) begin
                    bank_full_d[rbank_q] = 1'b0;
                    if (full_eff[~rbank_q]) rbank_d = ~rbank_q;
                    else                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            rbank_q     <= 1'b0;
            rcnt_q      <= '0;
            bank_full_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            rbank_q     <= rbank_d;
            rcnt_q      <= rcnt_d;
            bank_full_q <= bank_full_d;
        end
    end

    // Shift cannot overflow: the exponent never exceeds any sample's count.
    always_comb begin
        din_t shifted;
        shifted = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            shifted     = bank_q[rbank_q][rcnt_q][i] <<< bank_idx_q[rbank_q];
            dout_sel[i] = shifted[DIN_SIZE-1 -: DOUT_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out_q <= 1'b0;
            blk_last_q  <= 1'b0;
            index_q     <= '0;
            for (int i = 0; i < ARRAY_SIZE; i++) dout_q[i] <= '0;
        end else begin
            valid_out_q <= (state_q == EMIT);
            blk_last_q  <= emit_last;
            if (state_q == EMIT) begin
                index_q <= bank_idx_q[rbank_q];
                for (int i = 0; i < ARRAY_SIZE; i++) dout_q[i] <= dout_sel[i];
            end
        end
    end

    assign valid_out    = valid_out_q;
    assign blk_last_out = blk_last_q;
    assign index_out    = index_q;
    assign dout         = dout_q;

endmodule

// File: tb/tb_cbfp_blk_normalize.sv
// tb_cbfp_blk_normalize
// Directed bench for cbfp_blk_normalize: each block is a constant base value
// with one special sample; exponent and normalized outputs are hand-derived.
module tb_cbfp_blk_normalize;
    import cbfp_pkg::*;

    typedef logic [ARRAY_SIZE-1:0][DOUT_SIZE-1:0] beat_t;

    typedef struct packed {
        beat_t               d;
        logic [IDX_SIZE-1:0] idx;
        logic                last;
        int                  cyc;
    } obs_t;

    typedef struct packed {
        beat_t [BLK_BEATS-1:0] d;
        logic [IDX_SIZE-1:0]   idx;
        int                    lastCyc;
    } exp_t;

    logic                        clk = 1'b0;
    logic                        rstn = 1'b0;
    logic                        valid_in = 1'b0;
    logic signed [DIN_SIZE-1:0]  din [0:ARRAY_SIZE-1];
    logic                        valid_out;
    logic signed [DOUT_SIZE-1:0] dout [0:ARRAY_SIZE-1];
    logic [IDX_SIZE-1:0]         index_out;
    logic                        blk_last_out;

    int   errCnt = 0;
    int   chkCnt = 0;
    int   cycleCnt = 0;
    obs_t obsQ[$];
    exp_t expQ[$];
    exp_t curExp;
    logic [DIN_SIZE-1:0] blkIn [BLK_BEATS][ARRAY_SIZE];

    cbfp_blk_normalize dut (
        .clk          (clk),
        .rstn         (rstn),
        .valid_in     (valid_in),
        .din          (din),
        .valid_out    (valid_out),
        .dout         (dout),
        .index_out    (index_out),
        .blk_last_out (blk_last_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Record every output beat with the index of the edge that produced it.
    always @(negedge clk) begin : mon
        obs_t o;
        if (valid_out) begin
            for (int i = 0; i < ARRAY_SIZE; i++) o.d[i] = dout[i];
            o.idx  = index_out;
            o.last = blk_last_out;
            o.cyc  = cycleCnt;
            obsQ.push_back(o);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        chkCnt++;
        if (obs !== expv) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic randomizeDin();
        for (int i = 0; i < ARRAY_SIZE; i++) din[i] = DIN_SIZE'($urandom);
    endtask

    task automatic setBlock(input logic [DIN_SIZE-1:0] base, input logic [DIN_SIZE-1:0] spec,
                            input int sBeat, input int sLane,
                            input logic [DOUT_SIZE-1:0] expBase, input logic [DOUT_SIZE-1:0] expSpec,
                            input logic [IDX_SIZE-1:0] expIdx);
        for (int b = 0; b < BLK_BEATS; b++) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                blkIn[b][i]     = (b == sBeat && i == sLane) ? spec : base;
                curExp.d[b][i]  = (b == sBeat && i == sLane) ? expSpec : expBase;
            end
        end
        curExp.idx     = expIdx;
        curExp.lastCyc = 0;
    endtask

    // Drives nBeats of the current block; gaps[b] idle cycles precede beat b.
    task automatic applyStimulus(input logic [BLK_BEATS-1:0][7:0] gaps, input int nBeats);
        for (int b = 0; b < nBeats; b++) begin
            for (int g = 0; g < int'(gaps[b]); g++) begin
                valid_in = 1'b0;
                randomizeDin();
                @(negedge clk);
            end
            valid_in = 1'b1;
            for (int i = 0; i < ARRAY_SIZE; i++) din[i] = blkIn[b][i];
            @(negedge clk);
            curExp.lastCyc = cycleCnt;
        end
        valid_in = 1'b0;
        if (nBeats == BLK_BEATS) expQ.push_back(curExp);
    endtask

    task automatic collectBlocks(input int nBlk);
        int waitCyc;
        waitCyc = 0;
        while (obsQ.size() < nBlk * BLK_BEATS && waitCyc < 100) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        checkOutput("beat count", obsQ.size(), nBlk * BLK_BEATS);
        for (int bl = 0; bl < nBlk; bl++) begin
            exp_t e;
            if (expQ.size() == 0) break;
            e = expQ.pop_front();
            for (int k = 0; k < BLK_BEATS; k++) begin
                obs_t o;
                if (obsQ.size() == 0) break;
                o = obsQ.pop_front();
                checkOutput($sformatf("beat %0d cycle", k), o.cyc, e.lastCyc + 1 + k);
                checkOutput($sformatf("beat %0d index_out", k), o.idx, e.idx);
                checkOutput($sformatf("beat %0d blk_last_out", k), o.last, (k == BLK_BEATS - 1));
                for (int i = 0; i < ARRAY_SIZE; i++)
                    checkOutput($sformatf("beat %0d dout[%0d]", k, i), o.d[i], e.d[k][i]);
            end
        end
    endtask

    initial begin
        randomizeDin();
        repeat (5) begin
            @(negedge clk);
            randomizeDin();
            valid_in = 1'($urandom_range(0, 1));
        end
        checkOutput("reset valid_out", valid_out, 0);
        checkOutput("reset index_out", index_out, 0);
        checkOutput("reset blk_last_out", blk_last_out, 0);
        for (int i = 0; i < ARRAY_SIZE; i++) checkOutput($sformatf("reset dout[%0d]", i), dout[i], 0);
        valid_in = 1'b0;
        rstn     = 1'b1;
        @(negedge clk);

        // 0x400 has 11 redundant bits, 0x1000 has 9 -> exp 9; outputs 2^19, 2^21 >> 12
        setBlock(23'h000400, 23'h001000, 1, 7, 11'h080, 11'h200, 5'd9);
        applyStimulus(32'd0, 4);
        collectBlocks(1);

        // -2^22 has no redundant bits -> exp 0, top 11 bits are 0x400 (-1024)
        setBlock(23'h000000, 23'h400000, 2, 0, 11'h000, 11'h400, 5'd0);
        applyStimulus(32'd0, 4);
        collectBlocks(1);

        setBlock(23'h000000, 23'h000000, 0, 0, 11'h000, 11'h000, 5'd22);
        applyStimulus(32'd0, 4);
        collectBlocks(1);

        setBlock(23'h3FFFFF, 23'h3FFFFF, 0, 0, 11'h3FF, 11'h3FF, 5'd0);
        applyStimulus(32'd0, 4);
        collectBlocks(1);

        // Gapped: accepts at relative cycles 0, 3, 4, 9; smallest count sits in beat 0
        setBlock(23'h000100, 23'h000800, 0, 5, 11'h040, 11'h200, 5'd10);
        applyStimulus({8'd4, 8'd0, 8'd2, 8'd0}, 4);
        collectBlocks(1);

        // Three back-to-back blocks
        setBlock(23'h000001, 23'h000100, 3, 15, 11'h002, 11'h200, 5'd13);
        applyStimulus(32'd0, 4);
        setBlock(23'h7FFF00, 23'h7FC000, 1, 3, 11'h7F0, 11'h400, 5'd8);
        applyStimulus(32'd0, 4);
        setBlock(23'h000000, 23'h000010, 2, 9, 11'h000, 11'h200, 5'd17);
        applyStimulus(32'd0, 4);
        collectBlocks(3);

        // Partial block interrupted by reset must never be emitted
        setBlock(23'h000001, 23'h000001, 0, 0, 11'h000, 11'h000, 5'd0);
        applyStimulus(32'd0, 3);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("mid reset valid_out", valid_out, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("partial block beats", obsQ.size(), 0);

        setBlock(23'h000002, 23'h7FFFFD, 3, 0, 11'h200, 11'h500, 5'd20);
        applyStimulus(32'd0, 4);
        collectBlocks(1);

        repeat (6) @(negedge clk);
        checkOutput("extra beats", obsQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
